bus_rr_sched: RTL and testbench
===============================

Name: bus_rr_sched

Overview:
- Round-robin scheduler that shares a single transfer bus between `drvrs` driver-side FIFOs and routes each packet to the destination FIFO(s).
- Sits between the per-driver FIFO models and the receive FIFOs.
- Sequences every transfer as pop, then latch, then push, with a bounded burst per grant.
- Decodes the destination ID from the packet MSBs; supports broadcast and drops illegal destinations.

Parameters:
- drvrs, 4, number of requesters and destinations.
- pckg_sz, 16, packet width in bits.
- id_bits, 8, width of the destination field at `[pckg_sz-1 -: id_bits]`.
- broadcast, {8{1'b1}}, destination ID meaning "all except source".
- max_burst, 4, maximum packets moved per grant (>=1).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- pndng  in  drvrs  bit i high = driver FIFO i is non-empty.
- D_pop  in  drvrs*pckg_sz  head data of each FIFO; slice i is `[i*pckg_sz +: pckg_sz]`.
- pop  out  drvrs  one-hot, 1-cycle pop strobe to the granted FIFO.
- push  out  drvrs  push strobe(s) to destination FIFO(s).
- D_push  out  pckg_sz  shared bus data, valid while any push bit is high.
- grant  out  drvrs  one-hot current owner; 0 when idle.
- bus_busy  out  1  high in any state other than IDLE.
- err_dest  out  1  1-cycle pulse when a packet is dropped.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE; pop, push, grant, err_dest, bus_busy = 0; D_push = 0.
  - Round-robin pointer last_g = drvrs-1, so driver 0 wins first.
  - burst_cnt = 0.
  - Reset mid-transfer aborts at the next edge. A packet already popped but not pushed is lost; this is intended.
- IDLE:
  - If pndng != 0, pick the first set bit searching from last_g+1 with wrap-around.
  - Register grant = onehot(winner), burst_cnt = 0, go to POP.
  - Otherwise stay in IDLE.
- POP:
  - pop = grant for exactly this cycle.
  - Latch `D_pop[winner]` into data_q. Go to PUSH.
- PUSH:
  - D_push = data_q. dest = `data_q[pckg_sz-1 -: id_bits]`.
  - dest == broadcast: push = all ones except the winner bit.
  - dest < drvrs and dest != winner: push = onehot(dest).
  - Otherwise (dest >= drvrs and not broadcast, or dest == winner): push = 0, err_dest = 1, packet dropped.
  - burst_cnt increments on every PUSH, including drops.
  - Next state:
    - If burst_cnt+1 < max_burst and pndng[winner]==1 (post-pop value), go to POP.
    - Otherwise set last_g = winner, grant = 0, go to IDLE.
- Latency:
  - pndng sampled high in IDLE at cycle N gives pop at N+1 and push at N+2.
  - Burst throughput is 1 packet per 2 cycles.
  - Re-arbitration costs one IDLE cycle.
- Fairness: with all requesters pending continuously, grants rotate 0,1,...,drvrs-1,0. No requester waits more than (drvrs-1)·(2·max_burst+1) cycles.
- No back-pressure input: destination FIFOs are sized by the environment. Overflow is outside this block's responsibility.
- pndng toggling in POP or PUSH does not disturb the current transfer. Only the PUSH-cycle value controls burst continuation.

Optional Feature:
- Macro: BUS_SCHED_STATS_EN.
- Defined:
  - Adds outputs pkt_cnt[31:0] and drop_cnt[31:0].
  - pkt_cnt increments on each PUSH with push != 0 (broadcast counts once).
  - drop_cnt increments on each err_dest.
  - Both are cleared by reset and saturate at all-ones.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package bus_sched_pkg:
  - State enum {IDLE, POP, PUSH} (2 bits).
  - Function dest_of(pkt) returning the ID field.
  - Default broadcast constant.
- Sub-module bus_rr_pick: purely combinational rotating-priority encoder.
  - Inputs: req[drvrs], last_g.
  - Outputs: onehot winner and its index, plus valid.
  - Instantiated once.

Test Plan:
- Single packet: after reset, pndng=4'b0010 with D_pop slice1=16'h0301 -> pop=0010 at N+1; push=1000 and D_push=16'h0301 at N+2; then IDLE, grant=0.
- Broadcast: driver 2 sends 16'hFFAA -> push=1011, D_push=16'hFFAA for one cycle, err_dest=0.
- Illegal destination and self-destination: driver 0 sends 16'h07xx, then 16'h00xx -> two err_dest pulses, push stays 0, burst_cnt still advances.
- Burst cap: max_burst=4, driver 1 holds 6 packets and driver 3 holds 1 -> four driver-1 transfers, then driver 3, then the remaining two from driver 1.
- Rotation: pndng=1111 held constantly, max_burst=1 -> grant sequence 0001,0010,0100,1000,0001, each held 2 cycles with 1 IDLE cycle between.
- Reset mid-op: assert reset during PUSH -> next edge gives all outputs 0, state IDLE; after release, driver 0 wins first.

Source files
------------

// File: rtl/bus_sched_pkg.sv
// Shared types and helpers for the round-robin bus scheduler.
// Holds the FSM state encoding, the destination-field extractor and the default broadcast ID.
package bus_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } state_e;

    localparam int MAX_PKT_W = 64;
    localparam int MAX_ID_W  = 32;

    localparam logic [7:0] BCAST_DEF = 8'hFF;

    // Widths are passed in so one helper serves every packet/ID geometry up to the maxima above.
    function automatic logic [MAX_ID_W-1:0] dest_of(input logic [MAX_PKT_W-1:0] pkt,
                                                   input int pkt_w,
                                                   input int id_w);
        logic [MAX_PKT_W-1:0] mask;
        mask = (MAX_PKT_W'(1) << id_w) - MAX_PKT_W'(1);
        return MAX_ID_W'((pkt >> (pkt_w - id_w)) & mask);
    endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational rotating-priority encoder: first set request after last_g, wrapping around.
module bus_rr_pick #(
    parameter int drvrs = 4,
    parameter int iw    = (drvrs > 1) ? $clog2(drvrs) : 1
) (
    input  logic [drvrs-1:0] req,
    input  logic [iw-1:0]    last_g,
    output logic [drvrs-1:0] win_oh,
    output logic [iw-1:0]    win_idx,
    output logic             valid
);

    always_comb begin
        int cand;
        win_idx = '0;
        valid   = 1'b0;
        cand    = 0;
        // Scan farthest-first so the nearest candidate after last_g is the final write.
        for (int k = drvrs; k >= 1; k--) begin
            cand = (int'(last_g) + k) % drvrs;
            if (req[cand]) begin
                win_idx = iw'(cand);
                valid   = 1'b1;
            end
        end
        win_oh = valid ? (drvrs'(1) << win_idx) : '0;
    end

endmodule

// File: rtl/bus_rr_sched.sv
// Round-robin transfer-bus scheduler: pop -> latch -> push with bounded bursts per grant.
// Optional statistics counters are enabled with `define BUS_SCHED_STATS_EN.
module bus_rr_sched
    import bus_sched_pkg::*;
#(
    parameter int                 drvrs     = 4,
    parameter int                 pckg_sz   = 16,
    parameter int                 id_bits   = 8,
    parameter logic [id_bits-1:0] broadcast = id_bits'(BCAST_DEF),
    parameter int                 max_burst = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [drvrs-1:0]           pndng,
    input  logic [drvrs*pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]           pop,
    output logic [drvrs-1:0]           push,
    output logic [pckg_sz-1:0]         D_push,
    output logic [drvrs-1:0]           grant,
    output logic                       bus_busy,
    output logic                       err_dest
`ifdef BUS_SCHED_STATS_EN
    ,
    output logic [31:0]                pkt_cnt,
    output logic [31:0]                drop_cnt
`endif
);

    localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;
    localparam int BW = $clog2(max_burst + 1);

    state_e               state;
    logic [IW-1:0]        last_g;
    logic [IW-1:0]        win_idx;
    logic [BW-1:0]        burst_cnt;
    logic [pckg_sz-1:0]   data_q;

    logic [drvrs-1:0]     pick_oh;
    logic [IW-1:0]        pick_idx;
    logic                 pick_vld;
    logic [MAX_ID_W-1:0]  dest;
    logic                 more;

    bus_rr_pick #(
        .drvrs (drvrs),
        .iw    (IW)
    ) u_pick (
        .req     (pndng),
        .last_g  (last_g),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .valid   (pick_vld)
    );

    assign dest = dest_of(MAX_PKT_W'(data_q), pckg_sz, id_bits);
    // pndng here is already the post-pop value, so an emptied FIFO ends the burst.
    assign more = ((int'(burst_cnt) + 1) < max_burst) && pndng[win_idx];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            grant     <= '0;
            win_idx   <= '0;
            last_g    <= IW'(drvrs - 1);
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant     <= pick_oh;
                        win_idx   <= pick_idx;
                        burst_cnt <= '0;
                        state     <= POP;
                    end
                end
                POP: state <= PUSH;
                PUSH: begin
                    burst_cnt <= burst_cnt + BW'(1);
                    if (more) begin
                        state <= POP;
                    end else begin
                        last_g <= win_idx;
                        grant  <= '0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Head data is sampled on the edge that ends the pop strobe, before the FIFO advances.
    always_ff @(posedge clk) begin
        if (state == POP)
            data_q <= D_pop[win_idx*pckg_sz +: pckg_sz];
    end

    always_comb begin
        pop      = '0;
        push     = '0;
        D_push   = '0;
        err_dest = 1'b0;
        case (state)
            POP: pop = grant;
            PUSH: begin
                D_push = data_q;
                if (dest == MAX_ID_W'(broadcast))
                    push = ~grant;
                else if ((dest < MAX_ID_W'(drvrs)) && (dest != MAX_ID_W'(win_idx)))
                    push = drvrs'(1) << dest;
                else
                    err_dest = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus_busy = (state != IDLE);

`ifdef BUS_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if ((push != '0) && (pkt_cnt != '1))
                pkt_cnt <= pkt_cnt + 32'd1;
            if (err_dest && (drop_cnt != '1))
                drop_cnt <= drop_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bus_rr_sched.sv
// Self-checking bench for bus_rr_sched: transaction-level scoreboard fed by queue-based FIFO models.
module tb_bus_rr_sched;

    localparam int N  = 4;
    localparam int PW = 16;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      pndng;
    logic [N*PW-1:0]   D_pop;
    logic [N-1:0]      pop;
    logic [N-1:0]      push;
    logic [PW-1:0]     D_push;
    logic [N-1:0]      grant;
    logic              bus_busy;
    logic              err_dest;
`ifdef BUS_SCHED_STATS_EN
    logic [31:0]       pkt_cnt;
    logic [31:0]       drop_cnt;
`endif

    bus_rr_sched #(
        .drvrs     (N),
        .pckg_sz   (PW),
        .id_bits   (8),
        .broadcast (8'hFF),
        .max_burst (MB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .grant    (grant),
        .bus_busy (bus_busy),
        .err_dest (err_dest)
`ifdef BUS_SCHED_STATS_EN
        ,
        .pkt_cnt  (pkt_cnt),
        .drop_cnt (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int m_last = N - 1;
    int exp_pkts = 0;
    int exp_drops = 0;

    logic [PW-1:0] fq [N][$];
    logic [N-1:0]  pend_pop;

    int            pop_src [$];
    int            obs_cyc [$];
    logic [N-1:0]  obs_push [$];
    logic [PW-1:0] obs_data [$];
    logic          obs_err [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            pndng[i] = (fq[i].size() != 0);
            D_pop[i*PW +: PW] = (fq[i].size() != 0) ? fq[i][0] : '0;
        end
    endtask

    // One clock: retire the FIFO pop strobed last cycle, then sample and log DUT activity.
    task automatic step();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < N; i++)
            if (pend_pop[i] && fq[i].size() != 0) void'(fq[i].pop_front());
        refresh();
        pend_pop = pop;
        if (pop != '0) begin
            chk("pop_onehot", 64'($onehot(pop)), 64'd1);
            pop_src.push_back(idx_of(pop));
        end
        if (push != '0 || err_dest) begin
            obs_cyc.push_back(cyc);
            obs_push.push_back(push);
            obs_data.push_back(D_push);
            obs_err.push_back(err_dest);
        end
    endtask

    function automatic logic [7:0] rand_dest();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return 8'($urandom_range(0, N - 1));
        if (r < 8) return 8'hFF;
        return 8'($urandom_range(N, 254));
    endfunction

    // Predict the whole transfer sequence from the loaded FIFOs, run the DUT to idle, compare.
    task automatic run_episode(input string name);
        logic [PW-1:0] mq [N][$];
        int            exp_src [$];
        logic [PW-1:0] exp_pkt [$];
        logic [N-1:0]  exp_push [$];
        logic          exp_err [$];
        int            exp_gap [$];
        int            start, prev, s, n, nev;
        logic [PW-1:0] pkt;
        logic [7:0]    d;
        bit            any, done;

        for (int i = 0; i < N; i++) mq[i] = fq[i];
        pop_src.delete(); obs_cyc.delete(); obs_push.delete(); obs_data.delete(); obs_err.delete();

        any = 1'b1;
        while (any) begin
            any = 1'b0;
            s = -1;
            for (int k = 1; k <= N; k++)
                if (s < 0 && mq[(m_last + k) % N].size() != 0) s = (m_last + k) % N;
            if (s >= 0) begin
                any = 1'b1;
                n = 0;
                while (n < MB && mq[s].size() != 0) begin
                    pkt = mq[s].pop_front();
                    d = pkt[PW-1 -: 8];
                    exp_src.push_back(s);
                    exp_pkt.push_back(pkt);
                    exp_gap.push_back((n == 0 && exp_gap.size() != 0) ? 3 : 2);
                    if (d == 8'hFF) begin
                        exp_push.push_back(~(N'(1) << s));
                        exp_err.push_back(1'b0);
                    end else if (d < N && d != 8'(s)) begin
                        exp_push.push_back(N'(1) << d);
                        exp_err.push_back(1'b0);
                    end else begin
                        exp_push.push_back('0);
                        exp_err.push_back(1'b1);
                    end
                    n++;
                end
                m_last = s;
            end
        end

        refresh();
        start = cyc;
        done = 1'b0;
        for (int t = 0; t < 1000 && !done; t++) begin
            step();
            done = !bus_busy && pend_pop == '0;
            for (int i = 0; i < N; i++) if (fq[i].size() != 0) done = 1'b0;
        end
        if (!done) chk({name, ".timeout"}, 64'd1, 64'd0);

        chk({name, ".n_pop"}, 64'(pop_src.size()), 64'(exp_src.size()));
        chk({name, ".n_push"}, 64'(obs_push.size()), 64'(exp_push.size()));
        nev = (obs_push.size() < exp_push.size()) ? obs_push.size() : exp_push.size();
        if (pop_src.size() < nev) nev = pop_src.size();
        prev = start;
        for (int k = 0; k < nev; k++) begin
            chk({name, ".src"},  64'(pop_src[k]),  64'(exp_src[k]));
            chk({name, ".push"}, 64'(obs_push[k]), 64'(exp_push[k]));
            chk({name, ".data"}, 64'(obs_data[k]), 64'(exp_pkt[k]));
            chk({name, ".err"},  64'(obs_err[k]),  64'(exp_err[k]));
            chk({name, ".gap"},  64'(obs_cyc[k] - prev), 64'(exp_gap[k]));
            prev = obs_cyc[k];
        end
        for (int k = 0; k < exp_push.size(); k++) begin
            if (exp_push[k] != '0) exp_pkts++;
            if (exp_err[k]) exp_drops++;
        end
    endtask

    task automatic chk_quiet(input string name);
        chk({name, ".pop"},      64'(pop),      64'd0);
        chk({name, ".push"},     64'(push),     64'd0);
        chk({name, ".D_push"},   64'(D_push),   64'd0);
        chk({name, ".grant"},    64'(grant),    64'd0);
        chk({name, ".err_dest"}, 64'(err_dest), 64'd0);
        chk({name, ".bus_busy"}, 64'(bus_busy), 64'd0);
    endtask

    initial begin
        reset = 1'b0;
        pend_pop = '0;
        refresh();
        repeat (3) step();
        chk_quiet("reset");
        reset = 1'b1;
        step();

        fq[1].push_back(16'h0301);
        run_episode("single");
        chk("single.grant_idle", 64'(grant), 64'd0);

        fq[2].push_back(16'hFFAA);
        run_episode("bcast");

        fq[0].push_back(16'h0712);
        fq[0].push_back(16'h0034);
        run_episode("illegal");

        for (int k = 0; k < 6; k++) fq[1].push_back({8'(k % 2 == 0 ? 0 : 2), 8'(16 + k)});
        fq[3].push_back(16'h0177);
        run_episode("burst");

        for (int i = 0; i < N; i++)
            for (int k = 0; k < 8; k++) fq[i].push_back({8'($urandom_range(0, N - 1)), 8'($urandom)});
        run_episode("rotate");

        for (int e = 0; e < 25; e++) begin
            for (int i = 0; i < N; i++) begin
                int cnt;
                cnt = $urandom_range(0, 5);
                for (int k = 0; k < cnt; k++) fq[i].push_back({rand_dest(), 8'($urandom)});
            end
            run_episode("random");
        end

        // Abort a transfer in its PUSH cycle and confirm the next edge clears everything.
        fq[2].push_back(16'h0155);
        refresh();
        begin
            bit seen;
            seen = 1'b0;
            for (int t = 0; t < 10 && !seen; t++) begin
                step();
                seen = (push != '0);
            end
            chk("midrst.push_seen", 64'(push), 64'h2);
        end
        reset = 1'b0;
        step();
        pend_pop = '0;
        chk_quiet("midrst");
        reset = 1'b1;
        m_last = N - 1;
        exp_pkts = 0;
        exp_drops = 0;
        fq[3].push_back(16'h0011);
        fq[0].push_back(16'h0222);
        run_episode("after_rst");

`ifdef BUS_SCHED_STATS_EN
        chk("stats.pkt_cnt",  64'(pkt_cnt),  64'(exp_pkts));
        chk("stats.drop_cnt", 64'(drop_cnt), 64'(exp_drops));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
